// File: rtl/multi_square_top_if.sv
// Handshake bundle for multi_square_top: per-channel operand inputs and the shared result port.
// res_cnt exists only when SQ_RESULT_CNT_EN is defined.
interface multi_square_top_if #(
    parameter int NUM_CH = 4,
    parameter int W      = 4
);
    logic [NUM_CH-1:0]         in_valid;
    logic [NUM_CH-1:0]         in_ready;
    logic [NUM_CH*W-1:0]       in_n;
    logic                      out_valid;
    logic                      out_ready;
    logic [$clog2(NUM_CH)-1:0] out_ch;
    logic [2*W-1:0]            out_sq;
`ifdef SQ_RESULT_CNT_EN
    logic [NUM_CH*16-1:0]      res_cnt;
`endif

    modport master (
        output in_valid, in_n, out_ready,
        input  in_ready, out_valid, out_ch, out_sq
`ifdef SQ_RESULT_CNT_EN
        , input res_cnt
`endif
    );

    modport slave (
        input  in_valid, in_n, out_ready,
        output in_ready, out_valid, out_ch, out_sq
`ifdef SQ_RESULT_CNT_EN
        , output res_cnt
`endif
    );
endinterface

// File: rtl/multi_square_top.sv
// NUM_CH independent shift-add squarers sharing one registered output through a round-robin arbiter.
// Optional per-channel delivered-result counters are enabled with SQ_RESULT_CNT_EN.
module multi_square_top #(
    parameter int NUM_CH = 4,
    parameter int W      = 4
) (
    input logic               clk,
    input logic               rst,
    multi_square_top_if.slave bus
);
    localparam int CH_W  = $clog2(NUM_CH);
    localparam int CNT_W = $clog2(W);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(W - 1);

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

    state_t           st       [NUM_CH];
    logic [W-1:0]     opnd     [NUM_CH];
    logic [2*W-1:0]   acc      [NUM_CH];
    logic [CNT_W-1:0] bit_cnt  [NUM_CH];
    logic [2*W-1:0]   sum_next [NUM_CH];
    logic [2*W-1:0]   result   [NUM_CH];
    logic [NUM_CH-1:0] eligible;
    logic [NUM_CH-1:0] grant;
    logic [NUM_CH-1:0] in_ready_q;
    logic [CH_W-1:0]   ptr;
    logic [CH_W-1:0]   grant_idx;
    logic              grant_vld;
    logic              loadable;
    logic              out_valid_q;
    logic [CH_W-1:0]   out_ch_q;
    logic [2*W-1:0]    out_sq_q;

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_ch    = out_ch_q;
    assign bus.out_sq    = out_sq_q;
    assign loadable      = !out_valid_q || bus.out_ready;

    // A channel in its last CALC cycle competes with the completed sum so the
    // result can land in the output register on the same edge that finishes it.
    always_comb begin
        for (int unsigned k = 0; k < NUM_CH; k++) begin
            sum_next[k] = acc[k] + (opnd[k][bit_cnt[k]] ? ((2*W)'(opnd[k]) << bit_cnt[k]) : '0);
            eligible[k] = (st[k] == S_DONE) || ((st[k] == S_CALC) && (bit_cnt[k] == LAST_BIT));
            result[k]   = (st[k] == S_DONE) ? acc[k] : sum_next[k];
        end
    end

    always_comb begin
        grant_vld = 1'b0;
        grant_idx = '0;
        grant     = '0;
        if (loadable) begin
            for (int unsigned i = 0; i < NUM_CH; i++) begin
                if (!grant_vld && eligible[CH_W'((32'(ptr) + i) % NUM_CH)]) begin
                    grant_vld = 1'b1;
                    grant_idx = CH_W'((32'(ptr) + i) % NUM_CH);
                end
            end
        end
        if (grant_vld) grant[grant_idx] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned k = 0; k < NUM_CH; k++) begin
                st[k]      <= S_IDLE;
                opnd[k]    <= '0;
                acc[k]     <= '0;
                bit_cnt[k] <= '0;
            end
            in_ready_q  <= '1;
            out_valid_q <= 1'b0;
            out_ch_q    <= '0;
            out_sq_q    <= '0;
            ptr         <= '0;
        end else begin
            for (int unsigned k = 0; k < NUM_CH; k++) begin
                case (st[k])
                    S_IDLE: begin
                        if (bus.in_valid[k] && in_ready_q[k]) begin
                            st[k]         <= S_CALC;
                            opnd[k]       <= bus.in_n[k*W +: W];
                            acc[k]        <= '0;
                            bit_cnt[k]    <= '0;
                            in_ready_q[k] <= 1'b0;
                        end
                    end
                    S_CALC: begin
                        acc[k]     <= sum_next[k];
                        bit_cnt[k] <= bit_cnt[k] + 1'b1;
                        if (bit_cnt[k] == LAST_BIT) begin
                            if (grant[k]) begin
                                st[k]         <= S_IDLE;
                                in_ready_q[k] <= 1'b1;
                            end else begin
                                st[k] <= S_DONE;
                            end
                        end
                    end
                    S_DONE: begin
                        if (grant[k]) begin
                            st[k]         <= S_IDLE;
                            in_ready_q[k] <= 1'b1;
                        end
                    end
                    default: st[k] <= S_IDLE;
                endcase
            end

            if (grant_vld) begin
                out_valid_q <= 1'b1;
                out_ch_q    <= grant_idx;
                out_sq_q    <= result[grant_idx];
                ptr         <= (grant_idx == CH_W'(NUM_CH - 1)) ? '0 : grant_idx + 1'b1;
            end else if (bus.out_ready) begin
                out_valid_q <= 1'b0;
            end
        end
    end

`ifdef SQ_RESULT_CNT_EN
    logic [15:0] res_cnt_q [NUM_CH];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned k = 0; k < NUM_CH; k++) res_cnt_q[k] <= '0;
        end else if (out_valid_q && bus.out_ready && (res_cnt_q[out_ch_q] != 16'hFFFF)) begin
            res_cnt_q[out_ch_q] <= res_cnt_q[out_ch_q] + 1'b1;
        end
    end

    always_comb begin
        bus.res_cnt = '0;
        for (int unsigned k = 0; k < NUM_CH; k++) bus.res_cnt[k*16 +: 16] = res_cnt_q[k];
    end
`endif
endmodule

// File: doc/multi_square_top.md
MULTI_SQUARE_TOP -- requirements
Module: multi_square_top

Interface
REQ-001 The block SHALL have parameter NUM_CH, default 4, setting the number of independent squaring channels (legal range 2..16).
REQ-002 The block SHALL have parameter W, default 4, setting the operand width per channel (legal range 2..16).
REQ-003 The block SHALL have port clk, input, 1 bit, the single clock; all logic is on the rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit, reset; reset is synchronous and active-high.
REQ-005 The block SHALL have port in_valid, input, NUM_CH bits, per-channel operand valid.
REQ-006 The block SHALL have port in_ready, output, NUM_CH bits, per-channel operand ready.
REQ-007 The block SHALL have port in_n, input, NUM_CH*W bits, with channel k operand at bits [k*W +: W].
REQ-008 The block SHALL have port out_valid, output, 1 bit, result valid.
REQ-009 The block SHALL have port out_ready, input, 1 bit, result accepted by the sink.
REQ-010 The block SHALL have port out_ch, output, $clog2(NUM_CH) bits, the channel index of the current result.
REQ-011 The block SHALL have port out_sq, output, 2*W bits, the unsigned square of the operand.

Function
REQ-012 Each channel SHALL run an FSM with three states:
- IDLE: in_ready=1.
- CALC: shift-add multiply.
- DONE: result held, waiting for grant.
REQ-013 A channel SHALL transfer IDLE->CALC on in_valid&in_ready, latching the operand and clearing its accumulator and bit counter.
REQ-014 In CALC, the channel SHALL examine operand bit i once per cycle for i=0..W-1 and add (operand<<i) to a 2W-bit accumulator when the bit is set; the accumulator never overflows.
REQ-015 A channel SHALL transfer CALC->DONE after exactly W CALC cycles, and SHALL transfer DONE->IDLE in the cycle its result is granted.
REQ-016 The output stage SHALL be a single registered entry, loadable when it is empty or when out_valid&out_ready in that cycle.
REQ-017 When the output stage is loadable, a round-robin arbiter SHALL grant one DONE channel, searching from the pointer upward with wrap; after granting channel k the pointer SHALL become (k+1) mod NUM_CH.
REQ-018 Uncontended latency SHALL be W+1 cycles: operand accepted in cycle 0 gives out_valid asserted in cycle W+1.
REQ-019 While out_valid=1 and out_ready=0, out_ch and out_sq SHALL be held stable.
REQ-020 Back-pressure: a DONE channel SHALL hold its result indefinitely and keep in_ready=0.
REQ-021 A granted channel SHALL be IDLE, with in_ready=1, in the following cycle.
REQ-022 When all channels are DONE and out_ready=1 continuously, the block SHALL emit one result per cycle.
REQ-023 in_valid on a channel that is not IDLE SHALL be ignored.

Reset
REQ-024 On rst=1 at a clock edge, the block SHALL set:
- all channel FSMs to IDLE;
- in_ready to all ones on the following cycle;
- out_valid, out_ch and out_sq to 0;
- the arbiter pointer to 0.
REQ-025 Reset asserted mid-CALC or mid-DONE SHALL discard in-flight results without emitting them.

Configuration
REQ-026 With macro SQ_RESULT_CNT_EN defined, the block SHALL add output res_cnt, NUM_CH*16 bits, a per-channel 16-bit saturating count (stops at 65535) of results delivered (out_valid&out_ready), reset to 0.
REQ-027 Without SQ_RESULT_CNT_EN, port res_cnt and its counters SHALL be absent and all other behaviour SHALL be identical.

Verification (NUM_CH=4, W=4)
REQ-028 ch0 in_n=15 accepted at cycle 0, out_ready=1 -> out_valid=1, out_ch=0, out_sq=225 at cycle 5.
REQ-029 ch0..3 send n=1,2,3,4 in the same cycle, out_ready=1 -> out_sq=1,4,9,16 with out_ch=0,1,2,3 in cycles 5..8.
REQ-030 ch2 n=7, out_ready=0 for 10 cycles -> out_sq=49 and out_ch=2 stable; ch2 in_ready=0 once a second result is DONE; out_ready=1 then drains both results in order.
REQ-031 ch1 n=9 accepted, rst=1 in CALC cycle 2 -> no result emitted; out_valid=0 and in_ready=4'b1111 after reset.
REQ-032 ch3 n=0 -> out_sq=0 at cycle 5; ch0 n=8 and ch3 n=8 in the same cycle after a ch3 grant -> ch0 is granted first.
REQ-033 With SQ_RESULT_CNT_EN, 3 results delivered on ch1 -> res_cnt[31:16]=3; a forced count of 65535 plus one more delivery stays at 65535.
